// File: rtl/func_result_checker.sv
// Post-DUT comparison stage: settles, scans NUM_CH 32-bit channels one per cycle, reports pass/mismatches.
// Optional FUNC_CHECKER_DIFF_EN adds diff_acc, the OR of (dut^gold) over mismatching channels.
module func_result_checker #(
  parameter int NUM_CH = 4,
  parameter int SETTLE = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [32*NUM_CH-1:0]          dut_val,
  input  logic [32*NUM_CH-1:0]          gold_val,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [$clog2(NUM_CH+1)-1:0]   mismatch_cnt,
  output logic [$clog2(NUM_CH+1)-1:0]   first_fail_idx
`ifdef FUNC_CHECKER_DIFF_EN
  ,
  output logic [31:0]                   diff_acc
`endif
);

  localparam int CW        = $clog2(NUM_CH + 1);
  localparam int WAIT_LD_I = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam logic [3:0]    WAIT_LD = 4'(WAIT_LD_I);
  localparam logic [CW-1:0] NONE    = CW'(NUM_CH);
  localparam logic [CW-1:0] LAST    = CW'(NUM_CH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SCAN, S_DONE} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [3:0]     wait_cnt;
  logic [CW-1:0]  idx;
  logic [31:0]    dut_ch;
  logic [31:0]    gold_ch;
  logic [31:0]    ch_diff;
  logic           ch_mis;
  logic           last_ch;

  function automatic logic [31:0] ch_sel(input logic [32*NUM_CH-1:0] v,
                                         input logic [CW-1:0]         k);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (k == CW'(i)) r = v[32*i +: 32];
    end
    return r;
  endfunction

  // Inputs are sampled live during SCAN; no capture register in front of the compare.
  always_comb begin
    dut_ch  = ch_sel(dut_val, idx);
    gold_ch = ch_sel(gold_val, idx);
    ch_diff = dut_ch ^ gold_ch;
    ch_mis  = (state == S_SCAN) && (ch_diff != 32'd0);
    last_ch = (idx == LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = (SETTLE == 0) ? S_SCAN : S_SETTLE;
      S_SETTLE: if (wait_cnt == 4'd0) state_nxt = S_SCAN;
      S_SCAN:   if (last_ch) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state == S_SETTLE) || (state == S_SCAN);
  assign done = (state == S_DONE);

  // pass is registered on the last SCAN edge so it is already final in the DONE cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt       <= 4'd0;
      idx            <= '0;
      mismatch_cnt   <= '0;
      first_fail_idx <= NONE;
      pass           <= 1'b0;
`ifdef FUNC_CHECKER_DIFF_EN
      diff_acc       <= 32'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            wait_cnt       <= WAIT_LD;
            idx            <= '0;
            mismatch_cnt   <= '0;
            first_fail_idx <= NONE;
            pass           <= 1'b0;
`ifdef FUNC_CHECKER_DIFF_EN
            diff_acc       <= 32'd0;
`endif
          end
        end
        S_SETTLE: begin
          if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
        end
        S_SCAN: begin
          idx <= idx + CW'(1);
          if (ch_mis) begin
            mismatch_cnt <= mismatch_cnt + CW'(1);
            if (first_fail_idx == NONE) first_fail_idx <= idx;
`ifdef FUNC_CHECKER_DIFF_EN
            diff_acc <= diff_acc | ch_diff;
`else
            // Without the diff port only the count and first index are kept.
`endif
          end
          if (last_ch) pass <= (mismatch_cnt == '0) && !ch_mis;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/func_result_checker.md
# func_result_checker

Sequential comparison stage that consumes the integer results produced by a function-evaluating design under test (the w, x, y, z channel values) and checks them against a golden set. It sits directly downstream of the gate/gold module pair in equivalence-style test benches. On each `start`, it waits a settle period, then scans the channels one per cycle and reports pass/fail, the mismatch count and the first failing channel.

## Interface
- `NUM_CH`, 4: number of 32-bit integer channels compared; legal range 1..16.
- `SETTLE`, 2: wait cycles between an accepted `start` and the first compare; legal range 0..15.
- `clk`  input  1  clock; all logic is on the rising edge.
- `rst_n`  input  1  reset; synchronous, active-low.
- `start`  input  1  request a check; accepted only in IDLE.
- `dut_val`  input  32*NUM_CH  DUT results; channel i is bits [32*i+31:32*i]; channel 0 is w.
- `gold_val`  input  32*NUM_CH  expected results, same packing as `dut_val`.
- `busy`  output  1  high in SETTLE and SCAN.
- `done`  output  1  one-cycle pulse when a check completes.
- `pass`  output  1  last check had zero mismatches.
- `mismatch_cnt`  output  $clog2(NUM_CH+1)  mismatching channels in the last check.
- `first_fail_idx`  output  $clog2(NUM_CH+1)  lowest failing channel index; NUM_CH means none.
- `diff_acc`  output  32  OR of (dut^gold) over mismatching channels; present only with `FUNC_CHECKER_DIFF_EN`.

## Operation
- The FSM has four states: IDLE, SETTLE, SCAN and DONE.
- **IDLE**
  - On `start`=1, the check is accepted: clear `mismatch_cnt` and `diff_acc` to 0, set `first_fail_idx` to NUM_CH, set `pass` to 0.
  - Go to SETTLE, or straight to SCAN if SETTLE=0.
- **SETTLE**
  - A wait counter loads SETTLE-1 and decrements.
  - At 0 the FSM goes to SCAN with the channel index at 0.
- **SCAN**
  - Each cycle compares channel `idx` of `dut_val` against `gold_val`; inputs are sampled live that cycle.
  - On mismatch:
    - increment `mismatch_cnt`;
    - if `first_fail_idx`==NUM_CH, load it with `idx`;
    - OR the XOR into `diff_acc`.
  - After `idx`==NUM_CH-1, go to DONE.
- **DONE**
  - `done`=1 for this single cycle.
  - `pass` <= (`mismatch_cnt`==0), evaluated including the final channel.
  - Next state is IDLE.
- `start` is ignored in SETTLE, SCAN and DONE; it is not queued.
- Result outputs hold their values until the next accepted `start`.
- Comparison is a full 32-bit equality; there is no signedness or width extension.
- `mismatch_cnt` cannot overflow because its width covers NUM_CH.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `pass`=0, `mismatch_cnt`=0;
  - `first_fail_idx`=NUM_CH, `diff_acc`=0;
  - state is IDLE.
- With `start` sampled high at edge t:
  - `busy` rises after edge t;
  - channel i is compared in the cycle after edge t+SETTLE+i;
  - `done` is high for the one cycle after edge t+SETTLE+NUM_CH;
  - `busy` is 0 in that `done` cycle.
- Total latency from `start` to the `done` cycle is SETTLE+NUM_CH+1 cycles.
- A new `start` is accepted at the earliest in the cycle after `done`.
- `pass`, `mismatch_cnt`, `first_fail_idx` and `diff_acc` are stable and final in the `done` cycle.
- `rst_n`=0 at any edge, including mid-SETTLE or mid-SCAN:
  - the FSM returns to IDLE and all outputs take their reset values next cycle;
  - no `done` is emitted for the aborted check.
- Reset has priority over `start` when both are asserted in the same cycle.

## Configuration
- `FUNC_CHECKER_DIFF_EN` defined:
  - the `diff_acc` port and its accumulator exist;
  - it is cleared on an accepted `start` and updated in SCAN on mismatching channels.
- Not defined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- All match: NUM_CH=4, SETTLE=2, dut=gold={16,4,42,51}, pulse `start` -> `done` on the 7th cycle after `start`, `pass`=1, `mismatch_cnt`=0, `first_fail_idx`=4, `diff_acc`=0.
- Single mismatch: same as above but dut channel 2 = 41 -> `pass`=0, `mismatch_cnt`=1, `first_fail_idx`=2, `diff_acc`=0x3.
- Double mismatch: dut channel 1 = 5 and channel 3 = 50 -> `mismatch_cnt`=2, `first_fail_idx`=1, `diff_acc`=0x1.
- Start ignored while busy: hold `start`=1 for 10 cycles -> exactly one `done` in the first 8 cycles; a second check begins only after IDLE is re-entered.
- Reset mid-scan: deassert `rst_n` in the SCAN cycle for channel 1 -> next cycle `busy`=0, no `done`, `first_fail_idx`=4, `mismatch_cnt`=0.
- SETTLE=0, NUM_CH=1, dut=16, gold=16 -> `done` in the 2nd cycle after `start`, `pass`=1.
